// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Hands one convolution layer's three filter-output BRAMs over to the next
//   layer's RGB column input. It waits for the producer to finish, then sweeps
//   the BRAM address in raster order. Two line buffers per channel turn the
//   sample stream into 3-row columns, which leave through a 2-entry skid
//   buffer with valid/ready flow control. done fires once the consumer layer
//   has also finished.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle run request (honoured in IDLE only)
//   l0_done                  producer finished (sampled in WAIT_L0)
//   rd_en, rd_addr           shared read strobe/address to the three BRAMs
//   rd_data_0/1/2            BRAM data, valid one cycle after rd_en
//   col_r/g/b                column {row y-2, row y-1, row y} per channel
//   col_valid, col_ready     column handshake
//   l1_done                  consumer finished (sampled in WAIT_L1)
//   busy, done               busy outside IDLE; done pulse in DONE
//   stall_cnt                cycles with col_valid & !col_ready (optional)
//
// Build option
//   SEQ_STALL_CNT_EN  adds the saturating 32-bit stall_cnt output.
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_L0  | waiting for the producer layer to finish
// STREAM   | issuing raster-order BRAM reads
// DRAIN    | all reads issued; waiting for the skid and in-flight read to empty
// WAIT_L1  | waiting for the consumer layer to finish
// DONE     | one-cycle done pulse
module conv_layer_sequencer #(
  parameter int DATA_WIDTH = 22,
  parameter int IMG_W      = 222,
  parameter int IMG_H      = 222,
  parameter int ADDR_W     = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    l0_done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data_0,
  input  logic [DATA_WIDTH-1:0]   rd_data_1,
  input  logic [DATA_WIDTH-1:0]   rd_data_2,
  output logic [3*DATA_WIDTH-1:0] col_r,
  output logic [3*DATA_WIDTH-1:0] col_g,
  output logic [3*DATA_WIDTH-1:0] col_b,
  output logic                    col_valid,
  input  logic                    col_ready,
  input  logic                    l1_done,
  output logic                    busy,
  output logic                    done
`ifdef SEQ_STALL_CNT_EN
  ,output logic [31:0]            stall_cnt
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = 3 * DW;  // one pixel: {filter0, filter1, filter2}
  localparam int CW = 9 * DW;  // one column: {col_r, col_g, col_b}
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_L0, S_STREAM, S_DRAIN, S_WAIT_L1, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d, rd_x_q, rd_x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              inflight_q, inflight_d;
  logic              rd_row2_q, rd_row2_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     skid0_q, skid0_d, skid1_q, skid1_d;

  logic [PW-1:0]     lb0_mem [IMG_W];
  logic [PW-1:0]     lb1_mem [IMG_W];
  logic [PW-1:0]     lb0_rd, lb1_rd, new_pix;
  logic [CW-1:0]     col_word;
  logic              push, pop, can_issue, issue;

  assign new_pix = {rd_data_0, rd_data_1, rd_data_2};
  assign lb0_rd  = lb0_mem[rd_x_q];
  assign lb1_rd  = lb1_mem[rd_x_q];

  assign col_word = {lb1_rd[3*DW-1 -: DW], lb0_rd[3*DW-1 -: DW], rd_data_0,
                     lb1_rd[2*DW-1 -: DW], lb0_rd[2*DW-1 -: DW], rd_data_1,
                     lb1_rd[DW-1:0],       lb0_rd[DW-1:0],       rd_data_2};

  assign col_valid = (occ_q != 2'd0);
  assign pop       = col_valid & col_ready;
  // Only returns from rows >= 2 produce a column.
  assign push      = inflight_q & rd_row2_q;

  // Rows 0-1 never reach the skid, so they stream freely. Later rows reserve
  // a skid slot for every read that could still land in it.
  assign can_issue = (y_q < YW'(2)) ||
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign issue     = (state_q == S_STREAM) && can_issue;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    rd_x_d     = rd_x_q;
    rd_row2_d  = rd_row2_q;
    inflight_d = 1'b0;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_L0;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_WAIT_L0: if (l0_done) state_d = S_STREAM;
      S_STREAM: begin
        if (issue) begin
          inflight_d = 1'b1;
          rd_x_d     = x_q;
          rd_row2_d  = (y_q >= YW'(2));
          // The last address is held so rd_addr stays put after the sweep.
          if (addr_q == ADDR_LAST) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      S_DRAIN:   if (occ_q == 2'd0 && !inflight_q) state_d = S_WAIT_L1;
      S_WAIT_L1: if (l1_done) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (push) begin
      if (wr_ptr_q) skid1_d = col_word;
      else          skid0_d = col_word;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rd_x_q     <= '0;
      rd_row2_q  <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rd_x_q     <= rd_x_d;
      rd_row2_q  <= rd_row2_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  // Line buffers: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      lb1_mem[rd_x_q] <= lb0_rd;
      lb0_mem[rd_x_q] <= new_pix;
    end
  end

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign {col_r, col_g, col_b} = rd_ptr_q ? skid1_q : skid0_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start)
      stall_cnt_d = '0;
    else if (col_valid && !col_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
